alu_rr_sequencer: RTL and testbench
===================================

# alu_rr_sequencer

Issue and writeback stage wrapped around `alu_base`. It accepts one RV32I register-register (OP, opcode `0110011`) instruction through a valid/ready handshake and reads `rs1`/`rs2` from its internal 32×32 register file. It then drives `alu_base_enable`, `funct3`, `rs1_value` and `rs2_value` for exactly one cycle, and writes the registered `rd_value` back to `rd` on the following cycle. It is the only producer of `alu_base` operands and the only consumer of its result.

## Interface
Parameters:
- `XLEN`, 32: data width of the register file and operands.
- `REG_ADDR_W`, 5: register index width; 32 registers.

Ports:
- `clock`  in  1  single clock, all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  32  RV32I instruction word.
- `instr_ready`  out  1  sequencer can accept; handshake when `instr_valid & instr_ready` at a rising edge.
- `preload_en`  in  1  register-file preload write request.
- `preload_addr`  in  5  preload target register.
- `preload_data`  in  XLEN  preload value.
- `alu_base_enable`  out  1  operands valid for `alu_base`.
- `funct3`  out  3  `instr[14:12]` of the issued instruction.
- `rs1_value`  out  XLEN  register-file value of `rs1`.
- `rs2_value`  out  XLEN  register-file value of `rs2`.
- `rd_value`  in  XLEN  registered result from `alu_base`.
- `retire_valid`  out  1  one-cycle pulse: result being written.
- `retire_rd`  out  5  destination index of the retiring instruction.
- `retire_value`  out  XLEN  value being written; equals `rd_value`.
- `illegal_instr`  out  1  one-cycle pulse: accepted word rejected.

## Operation
- States are IDLE, EXEC and WB.
- **IDLE**
  - `instr_ready = !preload_en`.
  - On handshake with a legal word: latch `funct3`, the `rs1`/`rs2` register-file values and `rd`, then go to EXEC.
  - Legal means opcode `0110011` and funct7 `0000000`.
  - SUB and SRA (funct7 `0100000`) and all other encodings are illegal. For these, `illegal_instr` pulses in the next cycle, the state stays IDLE, and no register is written.
- **EXEC**: `alu_base_enable = 1` for exactly this cycle. Operands and `funct3` are stable. Next state is WB.
- **WB**
  - `retire_valid = 1`, `retire_rd = rd`, `retire_value = rd_value` (combinational pass-through).
  - At the rising edge ending WB, `regs[rd] <= rd_value` unless `rd == 0`.
  - Next state is IDLE.
- **Register file**
  - `x0` reads as 0 at all times; writes to it are dropped.
  - Reads for issue come from the current array contents. No forwarding is needed: only one instruction is in flight.
- **Preload**
  - Honoured only in IDLE: `regs[preload_addr] <= preload_data` (dropped if `preload_addr == 0`).
  - Ignored in EXEC and WB.
  - An instruction is never accepted in the same cycle as a preload.

## Timing
- **Reset values**: state IDLE, `instr_ready` 1 (if `preload_en` is low), `alu_base_enable` 0, `funct3` 0, `rs1_value` 0, `rs2_value` 0, `retire_valid` 0, `retire_rd` 0, `illegal_instr` 0.
- **Latency**
  - Handshake edge at cycle N.
  - EXEC in N+1; `alu_base` latches the result at the edge ending N+1.
  - WB in N+2; the register is written at the edge ending N+2.
  - Earliest next acceptance is the edge ending N+3.
- **Throughput**: one instruction per 3 cycles.
- **Back-to-back dependency**: a new instruction issued after WB reads the updated register.
- **`instr_valid` while not ready**: the word is not consumed; the upstream must hold it.
- **Reset asserted mid-operation**
  - Outputs take reset values immediately (asynchronous).
  - The in-flight instruction is discarded with no writeback.
  - Register-file contents are subject to the Configuration rule below.

## Configuration
- **`ALU_RR_SEQUENCER_REGFILE_RESET_EN` defined**: `reset` clears all 32 registers to 0.
- **Not defined**: the register file has no reset (maps to RAM). Contents are undefined until written; `x0` still reads 0.

## Test plan
- Preload `x1=5`, `x2=7`; issue ADD x3,x1,x2 (`0x002081B3`). Required: EXEC has `rs1_value=5`, `rs2_value=7`, `funct3=0`; WB has `retire_rd=3`, `retire_value=12`; `instr_ready` is low for exactly 2 cycles.
- Preload `x1=0xFFFFFFFF`, `x2=1`; issue SLT x4,x1,x2 then SLTU x5,x1,x2 back-to-back. Required: retire values 1 and 0; the second issue occurs 3 cycles after the first.
- Issue SUB x3,x1,x2 (`0x402081B3`). Required: `illegal_instr` pulses once, `alu_base_enable` never asserts, `x3` is unchanged.
- Issue ADD x0,x1,x2. Required: `retire_valid` pulses with `retire_rd=0`; a following issue reading `x0` sees 0.
- Assert `reset` during EXEC. Required: `alu_base_enable` drops asynchronously and no `retire_valid` appears. With the macro defined, `x1` then reads 0.
- Assert `preload_en` and `instr_valid` together in IDLE. Required: `instr_ready=0`, the preload is written, and the instruction is accepted the cycle after `preload_en` drops.

Source files
------------

// File: rtl/alu_rr_sequencer_if.sv
// Bus bundle between the issue/writeback sequencer and its neighbours:
// the instruction source, the register-file preload port, the alu_base
// operand/result pair, the retire port and the FSM debug view.
//
// instr_valid / instr_ready handshake:
//   - A word transfers on a rising edge where instr_valid and instr_ready
//     are both high.
//   - While instr_valid is high and instr_ready is low, the upstream holds
//     instr stable; nothing is consumed.
//   - instr_ready never depends on instr_valid, so there is no combinational
//     loop through the handshake.
interface alu_rr_sequencer_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);

  // Instruction handshake
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  instr_ready;

  // Register-file preload
  logic                  preload_en;
  logic [REG_ADDR_W-1:0] preload_addr;
  logic [XLEN-1:0]       preload_data;

  // alu_base operand / result pair
  logic                  alu_base_enable;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       rs1_value;
  logic [XLEN-1:0]       rs2_value;
  logic [XLEN-1:0]       rd_value;

  // Retire and error reporting
  logic                  retire_valid;
  logic [REG_ADDR_W-1:0] retire_rd;
  logic [XLEN-1:0]       retire_value;
  logic                  illegal_instr;

  // FSM state, for checkers and waveform reading (0 IDLE, 1 EXEC, 2 WB)
  logic [1:0]            fsm_state;

  // Sequencer side
  modport slave (
    input  instr_valid, instr,
    input  preload_en, preload_addr, preload_data,
    input  rd_value,
    output instr_ready,
    output alu_base_enable, funct3, rs1_value, rs2_value,
    output retire_valid, retire_rd, retire_value, illegal_instr,
    output fsm_state
  );

  // Environment side (instruction source, preload, alu_base, observers)
  modport master (
    output instr_valid, instr,
    output preload_en, preload_addr, preload_data,
    output rd_value,
    input  instr_ready,
    input  alu_base_enable, funct3, rs1_value, rs2_value,
    input  retire_valid, retire_rd, retire_value, illegal_instr,
    input  fsm_state
  );

endinterface

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: issue and writeback stage around alu_base.
// Accepts one RV32I register-register instruction at a time, reads its
// operands from an internal 32 x XLEN register file, presents them to
// alu_base for one cycle (EXEC) and writes the registered result back to
// rd on the next cycle (WB). One instruction per three cycles.
//
// Build option: ALU_RR_SEQUENCER_REGFILE_RESET_EN
//   defined   - reset clears every register to zero.
//   undefined - the register file has no reset so it can map onto RAM;
//               contents are undefined until written. x0 always reads 0.
module alu_rr_sequencer #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  alu_rr_sequencer_if.slave bus
);

  localparam int          NREGS     = 1 << REG_ADDR_W;
  localparam logic [6:0]  OPCODE_OP = 7'b0110011;
  localparam logic [6:0]  FUNCT7_OK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Register file storage; entry 0 is never written and never read out.
  logic [XLEN-1:0] regs [NREGS];

  // Decoded fields of the offered instruction word
  logic [6:0]            dec_opcode;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [2:0]            dec_funct3;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [6:0]            dec_funct7;
  logic                  dec_legal;

  // Issue-time register-file reads
  logic [XLEN-1:0]       rs1_read;
  logic [XLEN-1:0]       rs2_read;

  // Handshake and write qualifiers
  logic                  ready;
  logic                  accept;
  logic                  accept_legal;
  logic                  accept_illegal;
  logic                  wb_write;
  logic                  preload_write;

  // Operand and destination holding registers for the in-flight instruction
  logic [2:0]            funct3_q;
  logic [XLEN-1:0]       rs1_q;
  logic [XLEN-1:0]       rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;

  // Slice the instruction word into its R-type fields
  assign dec_opcode = bus.instr[6:0];
  assign dec_rd     = bus.instr[11:7];
  assign dec_funct3 = bus.instr[14:12];
  assign dec_rs1    = bus.instr[19:15];
  assign dec_rs2    = bus.instr[24:20];
  assign dec_funct7 = bus.instr[31:25];

  // Only plain OP encodings go to alu_base; SUB/SRA (funct7 0100000) and
  // anything else are rejected.
  assign dec_legal = (dec_opcode == OPCODE_OP) && (dec_funct7 == FUNCT7_OK);

  // Reads see the current array; only one instruction is ever in flight,
  // so no forwarding path is needed. x0 is forced to zero here.
  assign rs1_read = (dec_rs1 == '0) ? '0 : regs[dec_rs1];
  assign rs2_read = (dec_rs2 == '0) ? '0 : regs[dec_rs2];

  // Preload has priority over issue in IDLE, which keeps the two writers of
  // the array from ever meeting in the same cycle.
  assign ready          = (state == IDLE) && !bus.preload_en;
  assign accept         = bus.instr_valid && ready;
  assign accept_legal   = accept && dec_legal;
  assign accept_illegal = accept && !dec_legal;

  assign wb_write      = (state == WB) && (rd_q != '0);
  assign preload_write = (state == IDLE) && bus.preload_en &&
                         (bus.preload_addr != '0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-state outputs
  always_comb begin
    state_next           = state;
    bus.instr_ready      = 1'b0;
    bus.alu_base_enable  = 1'b0;
    bus.retire_valid     = 1'b0;
    bus.retire_rd        = '0;
    bus.retire_value     = bus.rd_value;
    unique case (state)
      IDLE: begin
        bus.instr_ready = ready;
        if (accept_legal) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        bus.alu_base_enable = 1'b1;
        state_next          = WB;
      end
      WB: begin
        bus.retire_valid = 1'b1;
        bus.retire_rd    = rd_q;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture operands and destination on a legal issue; flag rejected words
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept_illegal;
      if (accept_legal) begin
        funct3_q <= dec_funct3;
        rs1_q    <= rs1_read;
        rs2_q    <= rs2_read;
        rd_q     <= dec_rd;
      end
    end
  end

`ifdef ALU_RR_SEQUENCER_REGFILE_RESET_EN
  // Register file with reset: writeback in WB, preload in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[rd_q] <= bus.rd_value;
    end else if (preload_write) begin
      regs[bus.preload_addr] <= bus.preload_data;
    end
  end
`else
  // Register file without reset: writeback in WB, preload in IDLE
  always_ff @(posedge clock) begin
    if (wb_write) begin
      regs[rd_q] <= bus.rd_value;
    end else if (preload_write) begin
      regs[bus.preload_addr] <= bus.preload_data;
    end
  end
`endif

  // Operands stay on the bus from the issue edge until the next issue, so
  // they are stable for the whole EXEC cycle.
  assign bus.funct3        = funct3_q;
  assign bus.rs1_value     = rs1_q;
  assign bus.rs2_value     = rs2_q;
  assign bus.illegal_instr = illegal_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: a table of directed vectors, hand-written
// multi-cycle sequences, and a randomized phase checked against a
// register-array model. alu_base is stood in for by a registered ALU.
`timescale 1ns/1ps
module tb_alu_rr_sequencer;

  logic clock;
  logic reset;

  alu_rr_sequencer_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  alu_rr_sequencer #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    bit          legal;
    logic [31:0] result;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] ref_regs [32];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_hs  = 0;
  logic [31:0] seen_retire;
  logic [31:0] seen_illegal;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(negedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : ref_regs[r];
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // alu_base stand-in: registers the result at the edge ending EXEC
  always @(posedge clock) begin
    if (bus.alu_base_enable)
      bus.rd_value <= ref_alu(bus.funct3, bus.rs1_value, bus.rs2_value);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called between a falling and a rising edge; returns the same way.
  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    bus.preload_en   = 1'b1;
    bus.preload_addr = addr;
    bus.preload_data = data;
    @(posedge clock);
    @(negedge clock);
    bus.preload_en = 1'b0;
    if (addr != 5'd0) ref_regs[addr] = data;
  endtask

  // Offer a word, wait (bounded) for the handshake, then check EXEC/WB or
  // the illegal pulse. With keep set, instr_valid stays high carrying nxt.
  task automatic issue(input logic [31:0] w, input bit keep, input logic [31:0] nxt);
    bit          got;
    bit          legal;
    logic [31:0] a, b, expv;
    got = 1'b0;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.instr_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout actual=no_ready required=ready");
      bus.instr_valid = 1'b0;
      return;
    end
    legal = (w[6:0] == 7'b0110011) && (w[31:25] == 7'b0000000);
    a = ref_read(w[19:15]);
    b = ref_read(w[24:20]);
    @(posedge clock);
    last_hs = cyc;
    @(negedge clock);
    if (keep) bus.instr = nxt;
    else      bus.instr_valid = 1'b0;
    #1;
    seen_illegal = {31'd0, bus.illegal_instr};
    seen_retire  = 32'd0;
    if (legal) begin
      chk("exec_enable",  bus.alu_base_enable, 1);
      chk("exec_funct3",  bus.funct3, w[14:12]);
      chk("exec_rs1",     bus.rs1_value, a);
      chk("exec_rs2",     bus.rs2_value, b);
      chk("exec_ready",   bus.instr_ready, 0);
      chk("exec_illegal", bus.illegal_instr, 0);
      chk("exec_retire",  bus.retire_valid, 0);
      expv = ref_alu(w[14:12], a, b);
      exp_q.push_back(expv);
      @(negedge clock);
      #1;
      chk("wb_retire_valid", bus.retire_valid, 1);
      chk("wb_retire_rd",    bus.retire_rd, w[11:7]);
      chk("wb_retire_value", bus.retire_value, exp_q.pop_front());
      chk("wb_enable",       bus.alu_base_enable, 0);
      chk("wb_ready",        bus.instr_ready, 0);
      seen_retire = bus.retire_value;
      if (w[11:7] != 5'd0) ref_regs[w[11:7]] = expv;
      @(negedge clock);
      #1;
      chk("idle_retire_valid", bus.retire_valid, 0);
      chk("idle_ready",        bus.instr_ready, !bus.preload_en);
    end else begin
      chk("illegal_pulse",     bus.illegal_instr, 1);
      chk("illegal_no_enable", bus.alu_base_enable, 0);
      chk("illegal_no_retire", bus.retire_valid, 0);
    end
  endtask

  // Read a register through the issue path (ADD x0, r, x0)
  task automatic read_reg(input logic [4:0] r);
    issue(enc(7'd0, 5'd0, r, 3'd0, 5'd0, 7'h33), 1'b0, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int first_hs;
    int drop_cyc;
    logic [6:0] f7, op;
    int kind;

    vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        1'b1, 32'd12};
    vecs[1]  = '{32'h0020A233, 32'hFFFFFFFF, 32'd1,        1'b1, 32'd1};
    vecs[2]  = '{32'h0020B2B3, 32'hFFFFFFFF, 32'd1,        1'b1, 32'd0};
    vecs[3]  = '{32'h0020C333, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'hFF00FF00};
    vecs[4]  = '{32'h002093B3, 32'd1,        32'h24,       1'b1, 32'h10};
    vecs[5]  = '{32'h0020D433, 32'h80000000, 32'd3,        1'b1, 32'h10000000};
    vecs[6]  = '{32'h0020E4B3, 32'h0F,       32'hF0,       1'b1, 32'hFF};
    vecs[7]  = '{32'h0020F533, 32'hFF00,     32'h0FF0,     1'b1, 32'h0F00};
    vecs[8]  = '{32'h00208033, 32'd3,        32'd4,        1'b1, 32'd7};
    vecs[9]  = '{32'h402081B3, 32'd9,        32'd2,        1'b0, 32'd0};
    vecs[10] = '{32'h4020D433, 32'd9,        32'd2,        1'b0, 32'd0};
    vecs[11] = '{32'h00508193, 32'd9,        32'd2,        1'b0, 32'd0};
    vecs[12] = '{32'h022081B3, 32'd9,        32'd2,        1'b0, 32'd0};

    reset            = 1'b1;
    bus.instr_valid  = 1'b0;
    bus.instr        = 32'd0;
    bus.preload_en   = 1'b0;
    bus.preload_addr = 5'd0;
    bus.preload_data = 32'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;

    // Reset values
    repeat (3) @(negedge clock);
    #1;
    chk("rst_ready",   bus.instr_ready, 1);
    chk("rst_enable",  bus.alu_base_enable, 0);
    chk("rst_funct3",  bus.funct3, 0);
    chk("rst_rs1",     bus.rs1_value, 0);
    chk("rst_rs2",     bus.rs2_value, 0);
    chk("rst_retire",  bus.retire_valid, 0);
    chk("rst_rd",      bus.retire_rd, 0);
    chk("rst_illegal", bus.illegal_instr, 0);
    chk("rst_state",   bus.fsm_state, 0);
    @(negedge clock);
    reset = 1'b0;

    // Give every register a defined value
    for (int r = 1; r < 32; r++) preload(r[4:0], $urandom);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      preload(5'd1, vecs[i].a);
      preload(5'd2, vecs[i].b);
      issue(vecs[i].instr, 1'b0, 32'd0);
      chk("vec_illegal", seen_illegal, {31'd0, !vecs[i].legal});
      if (vecs[i].legal) begin
        chk("vec_result", seen_retire, vecs[i].result);
      end else begin
        @(negedge clock);
        #1;
        chk("illegal_once", bus.illegal_instr, 0);
        read_reg(vecs[i].instr[11:7]);
      end
    end

    // x0 reads zero after an ADD x0 retire
    issue(32'h001005B3, 1'b0, 32'd0);

    // Back-to-back SLT then SLTU held on the bus
    preload(5'd1, 32'hFFFFFFFF);
    preload(5'd2, 32'd1);
    issue(32'h0020A233, 1'b1, 32'h0020B2B3);
    chk("b2b_slt", seen_retire, 32'd1);
    first_hs = last_hs;
    issue(32'h0020B2B3, 1'b0, 32'd0);
    chk("b2b_sltu", seen_retire, 32'd0);
    chk("b2b_gap", last_hs - first_hs, 3);

    // Preload and instruction offered together
    bus.preload_en   = 1'b1;
    bus.preload_addr = 5'd12;
    bus.preload_data = 32'h12345678;
    bus.instr        = enc(7'd0, 5'd0, 5'd12, 3'd0, 5'd13, 7'h33);
    bus.instr_valid  = 1'b1;
    #1;
    chk("pl_ready_low", bus.instr_ready, 0);
    @(posedge clock);
    @(negedge clock);
    bus.preload_en = 1'b0;
    ref_regs[12] = 32'h12345678;
    #1;
    drop_cyc = cyc;
    issue(enc(7'd0, 5'd0, 5'd12, 3'd0, 5'd13, 7'h33), 1'b0, 32'd0);
    chk("pl_accept_cycle", last_hs, drop_cyc);

    // Preload during EXEC/WB is ignored
    bus.instr       = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33);
    bus.instr_valid = 1'b1;
    #1;
    @(posedge clock);
    @(negedge clock);
    bus.instr_valid  = 1'b0;
    bus.preload_en   = 1'b1;
    bus.preload_addr = 5'd14;
    bus.preload_data = 32'hDEADBEEF;
    #1;
    chk("exec_pl_ready", bus.instr_ready, 0);
    @(negedge clock);
    @(negedge clock);
    bus.preload_en = 1'b0;
    read_reg(5'd14);

    // Reset during EXEC
    bus.instr       = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd15, 7'h33);
    bus.instr_valid = 1'b1;
    #1;
    @(posedge clock);
    @(negedge clock);
    bus.instr_valid = 1'b0;
    #1;
    chk("rst_exec_enable", bus.alu_base_enable, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_enable", bus.alu_base_enable, 0);
    chk("rst_async_ready",  bus.instr_ready, 1);
    chk("rst_async_rs1",    bus.rs1_value, 0);
    @(negedge clock);
    reset = 1'b0;
`ifdef ALU_RR_SEQUENCER_REGFILE_RESET_EN
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("rst_no_retire", bus.retire_valid, 0);
    end
    read_reg(5'd1);
    read_reg(5'd15);

    // Randomized phase against the register-array model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        preload(5'($urandom_range(0, 31)), $urandom);
      end else begin
        kind = $urandom_range(0, 9);
        f7 = 7'd0;
        op = 7'h33;
        if (kind == 8)      f7 = 7'h20;
        else if (kind == 9) op = 7'h13;
        issue(enc(f7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), op),
              1'b0, 32'd0);
      end
    end
    for (int r = 0; r < 32; r++) read_reg(r[4:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
